// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry text updater.
// The struct widths follow the default grid and value sizes below.
package telem_pkg;

    localparam int DFLT_NUM_ROWS   = 4;
    localparam int DFLT_NUM_COLS   = 20;
    localparam int DFLT_NUM_REQ    = 4;
    localparam int DFLT_VAL_BITS   = 16;
    localparam int DFLT_MAX_DIGITS = 5;

    localparam int ROW_W = $clog2(DFLT_NUM_ROWS);
    localparam int COL_W = $clog2(DFLT_NUM_COLS);
    localparam int DIG_W = $clog2(DFLT_MAX_DIGITS + 1);

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_HASH  = 8'h23;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CONVERT,
        WRITE
    } state_t;

    typedef struct packed {
        logic [DFLT_VAL_BITS-1:0] value;
        logic [ROW_W-1:0]         row;
        logic [COL_W-1:0]         col;
        logic [DIG_W-1:0]         digits;
    } telem_req_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle for VAL_BITS cycles.
// ovf flags any non-zero digit beyond the requested field width.
module bin2bcd_seq
    import telem_pkg::*;
#(
    parameter int VAL_BITS   = DFLT_VAL_BITS,
    parameter int MAX_DIGITS = DFLT_MAX_DIGITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [VAL_BITS-1:0]                value,
    input  logic [$clog2(MAX_DIGITS+1)-1:0]    digits,
    output logic                               done,
    output logic [4*MAX_DIGITS-1:0]            bcd,
    output logic                               ovf
);

    localparam int BCD_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(VAL_BITS + 1);
    localparam int DW    = $clog2(MAX_DIGITS + 1);

    logic [VAL_BITS-1:0]   bin_reg;
    logic [BCD_W-1:0]      bcd_reg;
    logic [BCD_W-1:0]      bcd_adj;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DW-1:0]         digits_reg;
    logic                  lost_reg;
    logic [MAX_DIGITS-1:0] nib_over;

    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
            assign nib_over[gi] = (DW'(gi) >= digits_reg) && (bcd_reg[4*gi +: 4] != 4'd0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_reg    <= '0;
            bcd_reg    <= '0;
            cnt_reg    <= '0;
            digits_reg <= '0;
            lost_reg   <= 1'b0;
        end else if (start) begin
            bin_reg    <= value;
            bcd_reg    <= '0;
            cnt_reg    <= CNT_W'(VAL_BITS);
            digits_reg <= digits;
            lost_reg   <= 1'b0;
        end else if (cnt_reg != '0) begin
            // A carry out of the top digit means the value exceeds the BCD width
            bcd_reg  <= {bcd_adj[BCD_W-2:0], bin_reg[VAL_BITS-1]};
            bin_reg  <= {bin_reg[VAL_BITS-2:0], 1'b0};
            lost_reg <= lost_reg | bcd_adj[BCD_W-1];
            cnt_reg  <= cnt_reg - 1'b1;
        end
    end

    // done marks the cycle whose closing edge performs the final shift
    assign done = (cnt_reg == CNT_W'(1));
    assign bcd  = bcd_reg;
    assign ovf  = lost_reg | (|nib_over);

endmodule

// File: rtl/telemetry_text_updater.sv
// Arbitrates numeric-field writers, renders values as decimal ASCII into a shadow grid,
// and copies the shadow to the displayed grid only during vblank. Option: TELEM_LEADING_ZERO_BLANK_EN.
module telemetry_text_updater
    import telem_pkg::*;
#(
    parameter int NUM_ROWS   = DFLT_NUM_ROWS,
    parameter int NUM_COLS   = DFLT_NUM_COLS,
    parameter int NUM_REQ    = DFLT_NUM_REQ,
    parameter int VAL_BITS   = DFLT_VAL_BITS,
    parameter int MAX_DIGITS = DFLT_MAX_DIGITS
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              in_vblank,
    input  logic [NUM_REQ-1:0]                                req_valid,
    output logic [NUM_REQ-1:0]                                req_ready,
    input  logic [NUM_REQ-1:0][VAL_BITS-1:0]                  req_value,
    input  logic [NUM_REQ-1:0][$clog2(NUM_ROWS)-1:0]          req_row,
    input  logic [NUM_REQ-1:0][$clog2(NUM_COLS)-1:0]          req_col,
    input  logic [NUM_REQ-1:0][$clog2(MAX_DIGITS+1)-1:0]      req_digits,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]            chars,
    output logic                                              busy,
    output logic                                              commit,
    output logic                                              field_err
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW    = $clog2(MAX_DIGITS + 1);
    localparam int CW    = $clog2(NUM_COLS);

    state_t                                  state_reg, state_next;
    telem_req_t                              req_reg;
    logic [REQ_W-1:0]                        rr_ptr_reg;
    logic [DW-1:0]                           wr_idx_reg;
    logic                                    dirty_reg;
    logic                                    commit_reg;
    logic                                    field_err_reg;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]  shadow_reg;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]  chars_reg;
`ifdef TELEM_LEADING_ZERO_BLANK_EN
    logic                                    seen_nz_reg;
`endif

    logic                     commit_go;
    logic                     grant_found;
    logic [REQ_W-1:0]         grant_idx;
    logic                     grant_en;
    logic                     field_bad;
    logic                     conv_start;
    logic                     conv_done;
    logic [4*MAX_DIGITS-1:0]  conv_bcd;
    logic                     conv_ovf;
    logic [DW-1:0]            digit_pos;
    logic [3:0]               nib;
    logic                     wr_last;
    logic [CW-1:0]            wr_col;
    logic [7:0]               wr_char;

    // Committing a dirty shadow in vblank beats any pending request
    assign commit_go = (state_reg == IDLE) && in_vblank && dirty_reg;

    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = REQ_W'(cand);
            end
        end
    end

    assign grant_en = (state_reg == IDLE) && !commit_go && grant_found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == REQ_W'(gi));
        end
    endgenerate

    assign field_bad = (req_reg.digits == '0)
                    || (int'(req_reg.digits) > MAX_DIGITS)
                    || (int'(req_reg.row) >= NUM_ROWS)
                    || (int'(req_reg.col) + int'(req_reg.digits) > NUM_COLS);

    bin2bcd_seq #(
        .VAL_BITS   (VAL_BITS),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (conv_start),
        .value  (req_reg.value),
        .digits (req_reg.digits),
        .done   (conv_done),
        .bcd    (conv_bcd),
        .ovf    (conv_ovf)
    );

    // Most significant digit goes to the leftmost column
    assign digit_pos = req_reg.digits - 1'b1 - wr_idx_reg;
    assign nib       = conv_bcd[{digit_pos, 2'b00} +: 4];
    assign wr_last   = (wr_idx_reg == req_reg.digits - 1'b1);
    assign wr_col    = req_reg.col + CW'(wr_idx_reg);

    always_comb begin
        wr_char = ASCII_ZERO + {4'h0, nib};
        if (conv_ovf) begin
            wr_char = ASCII_HASH;
        end
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        else if (nib == 4'd0 && !seen_nz_reg && !wr_last) begin
            wr_char = ASCII_SPACE;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        case (state_reg)
            IDLE:    if (grant_en) state_next = CHECK;
            CHECK: begin
                if (field_bad) begin
                    state_next = IDLE;
                end else begin
                    state_next = CONVERT;
                    conv_start = 1'b1;
                end
            end
            CONVERT: if (conv_done) state_next = WRITE;
            WRITE:   if (wr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_reg       <= '0;
            rr_ptr_reg    <= '0;
            wr_idx_reg    <= '0;
            dirty_reg     <= 1'b0;
            commit_reg    <= 1'b0;
            field_err_reg <= 1'b0;
            shadow_reg    <= {(NUM_ROWS*NUM_COLS){ASCII_SPACE}};
            chars_reg     <= {(NUM_ROWS*NUM_COLS){ASCII_SPACE}};
`ifdef TELEM_LEADING_ZERO_BLANK_EN
            seen_nz_reg   <= 1'b0;
`endif
        end else begin
            commit_reg    <= commit_go;
            field_err_reg <= (state_reg == CHECK) && field_bad;
            if (commit_go) begin
                chars_reg <= shadow_reg;
                dirty_reg <= 1'b0;
            end
            if (grant_en) begin
                req_reg.value  <= req_value[grant_idx];
                req_reg.row    <= req_row[grant_idx];
                req_reg.col    <= req_col[grant_idx];
                req_reg.digits <= req_digits[grant_idx];
                rr_ptr_reg     <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
            if (state_reg == CONVERT) begin
                wr_idx_reg  <= '0;
`ifdef TELEM_LEADING_ZERO_BLANK_EN
                seen_nz_reg <= 1'b0;
`endif
            end
            if (state_reg == WRITE) begin
                shadow_reg[req_reg.row][wr_col] <= wr_char;
                wr_idx_reg <= wr_idx_reg + 1'b1;
`ifdef TELEM_LEADING_ZERO_BLANK_EN
                seen_nz_reg <= seen_nz_reg | (nib != 4'd0);
`endif
                if (wr_last) begin
                    dirty_reg <= 1'b1;
                end
            end
        end
    end

    assign chars     = chars_reg;
    assign busy      = (state_reg != IDLE);
    assign commit    = commit_reg;
    assign field_err = field_err_reg;

endmodule

// File: tb/tb_telemetry_text_updater.sv
// Scoreboard bench for telemetry_text_updater: stimulus queues expected grants, commits
// and field errors; a monitor pops and compares them when the DUT presents each event.
module tb_telemetry_text_updater;

    localparam int NR = 4;
    localparam int NC = 20;
    localparam int NQ = 4;

    typedef logic [NR-1:0][NC-1:0][7:0] grid_t;
    typedef struct packed {
        logic  is_commit;
        grid_t grid;
    } evt_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_vblank = 1'b0;
    logic [NQ-1:0]          req_valid = '0;
    logic [NQ-1:0]          req_ready;
    logic [NQ-1:0][15:0]    req_value = '0;
    logic [NQ-1:0][1:0]     req_row = '0;
    logic [NQ-1:0][4:0]     req_col = '0;
    logic [NQ-1:0][2:0]     req_digits = '0;
    grid_t                  chars;
    logic                   busy;
    logic                   commit;
    logic                   field_err;

    int    n_checks = 0;
    int    n_fail = 0;
    evt_t  evt_q[$];
    int    exp_grant[$];
    grid_t exp_shadow;
    grid_t exp_chars;
    grid_t spaces;

    telemetry_text_updater dut (
        .clk        (clk),
        .reset      (reset),
        .in_vblank  (in_vblank),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_value  (req_value),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_digits (req_digits),
        .chars      (chars),
        .busy       (busy),
        .commit     (commit),
        .field_err  (field_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_grid(input string name, input grid_t got, input grid_t exp);
        bit found;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            found = 1'b0;
            for (int r = 0; r < NR; r++) begin
                for (int c = 0; c < NC; c++) begin
                    if (!found && got[r][c] !== exp[r][c]) begin
                        found = 1'b1;
                        $display("FAIL %s: cell[%0d][%0d] got 8'h%02h, expected 8'h%02h",
                                 name, r, c, got[r][c], exp[r][c]);
                    end
                end
            end
        end
    endtask

    task automatic put_str(input int r, input int c, input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_shadow[r][c+i] = s[i];
        end
    endtask

    // Issue one request and return at the first falling edge after it is accepted
    task automatic send(input int idx, input int value, input int row, input int col,
                        input int dig, input bit expect_err);
        int tries;
        exp_grant.push_back(idx);
        if (expect_err) evt_q.push_back({1'b0, spaces});
        @(negedge clk);
        req_value[idx]  = 16'(value);
        req_row[idx]    = 2'(row);
        req_col[idx]    = 5'(col);
        req_digits[idx] = 3'(dig);
        req_valid[idx]  = 1'b1;
        tries = 0;
        #1;
        while (!req_ready[idx] && tries < 200) begin
            @(negedge clk);
            #1;
            tries++;
        end
        chk("send_granted_in_time", req_ready[idx], 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(output int cycles, input int limit);
        cycles = 0;
        while (busy && cycles < limit) begin
            cycles++;
            @(negedge clk);
        end
        if (busy) chk("wait_idle_timeout", busy, 0);
    endtask

    task automatic do_commit();
        exp_chars = exp_shadow;
        evt_q.push_back({1'b1, exp_shadow});
        @(negedge clk);
        in_vblank = 1'b1;
        repeat (3) @(negedge clk);
        in_vblank = 1'b0;
    endtask

    // Monitor: samples 2 time units after each falling edge
    initial begin
        logic [NQ-1:0] prev_ready;
        logic          prev_commit;
        evt_t          e;
        int            g;
        prev_ready  = '0;
        prev_commit = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_ready  = '0;
                prev_commit = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    chk("ready_onehot", $countones(req_ready), 1);
                    chk("ready_only_idle", busy, 0);
                end
                for (int i = 0; i < NQ; i++) begin
                    if (req_ready[i]) begin
                        chk("ready_single_cycle", prev_ready[i], 0);
                        if (exp_grant.size() == 0) begin
                            chk("unexpected_grant", i, -1);
                        end else begin
                            g = exp_grant.pop_front();
                            chk("grant_order", i, g);
                        end
                    end
                end
                if (commit) begin
                    chk("commit_pulse_width", prev_commit, 0);
                    if (evt_q.size() == 0) begin
                        chk("unexpected_commit", commit, 0);
                    end else begin
                        e = evt_q.pop_front();
                        chk("event_kind_commit", 1, e.is_commit);
                        chk_grid("commit_chars", chars, e.grid);
                    end
                end
                if (field_err) begin
                    if (evt_q.size() == 0) begin
                        chk("unexpected_field_err", field_err, 0);
                    end else begin
                        e = evt_q.pop_front();
                        chk("event_kind_field_err", 0, e.is_commit);
                    end
                end
                prev_ready  = req_ready;
                prev_commit = commit;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ngr;
        int cyc;
        int g;
        grid_t prev;
        spaces     = {(NR*NC){8'h20}};
        exp_shadow = spaces;
        exp_chars  = spaces;

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_grid("reset_chars", chars, spaces);
        chk("reset_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_commit", commit, 0);
        chk("reset_field_err", field_err, 0);

        // 12345 in 5 digits; latency and hold-until-vblank
        send(0, 12345, 1, 3, 5, 1'b0);
        put_str(1, 3, "12345");
        wait_idle(n, 100);
        chk("latency_5_digits", n, 22);
        repeat (4) @(negedge clk);
        chk_grid("chars_held_before_vblank", chars, spaces);
        chk("no_commit_before_vblank", commit, 0);
        do_commit();

        // Overflow fill, padding, zero and full-width values
        send(0, 12345, 0, 0, 4, 1'b0);
        put_str(0, 0, "####");
        wait_idle(n, 100);
        chk("latency_4_digits", n, 21);
        send(0, 7, 0, 5, 3, 1'b0);
        wait_idle(n, 100);
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        put_str(0, 5, "  7");
`else
        put_str(0, 5, "007");
`endif
        send(0, 0, 0, 9, 1, 1'b0);
        put_str(0, 9, "0");
        wait_idle(n, 100);
        chk("latency_1_digit", n, 18);
        send(0, 0, 0, 11, 3, 1'b0);
        wait_idle(n, 100);
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        put_str(0, 11, "  0");
`else
        put_str(0, 11, "000");
`endif
        send(0, 65535, 0, 15, 5, 1'b0);
        put_str(0, 15, "65535");
        wait_idle(n, 100);
        do_commit();

        // Bad fields are dropped after the one-cycle check
        send(0, 123, 2, 18, 3, 1'b1);
        wait_idle(n, 100);
        chk("bad_col_busy_cycles", n, 1);
        send(0, 5, 2, 0, 0, 1'b1);
        wait_idle(n, 100);
        chk("bad_zero_digits_busy_cycles", n, 1);
        send(0, 5, 2, 0, 6, 1'b1);
        wait_idle(n, 100);
        chk("bad_too_many_digits_busy_cycles", n, 1);
        repeat (3) @(negedge clk);
        chk_grid("bad_fields_chars_unchanged", chars, exp_chars);
        // Right-edge boundary and last-writer-wins overlap
        send(0, 999, 3, 17, 3, 1'b0);
        put_str(3, 17, "999");
        wait_idle(n, 100);
        chk("latency_3_digits", n, 20);
        send(0, 9, 1, 7, 1, 1'b0);
        put_str(1, 7, "9");
        wait_idle(n, 100);
        do_commit();

        // Round-robin with all requesters holding valid
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_shadow = spaces;
        exp_chars  = spaces;
        for (int i = 0; i < NQ; i++) begin
            req_value[i]  = 16'(i + 1);
            req_row[i]    = 2'd0;
            req_col[i]    = 5'(i);
            req_digits[i] = 3'd1;
        end
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        put_str(0, 0, "1234");
        @(negedge clk);
        req_valid = 4'hF;
        ngr = 0;
        cyc = 0;
        while (ngr < 5 && cyc < 500) begin
            #1;
            g = -1;
            for (int i = 0; i < NQ; i++) if (req_ready[i]) g = i;
            @(negedge clk);
            if (g >= 0) begin
                ngr++;
                if (g != 0 || ngr == 5) req_valid[g] = 1'b0;
            end
            cyc++;
        end
        chk("rr_grant_count", ngr, 5);
        req_valid = '0;
        wait_idle(n, 100);
        do_commit();

        // Vblank arriving mid-WRITE: commit only once back in IDLE
        send(0, 42, 2, 0, 5, 1'b0);
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        put_str(2, 0, "   42");
`else
        put_str(2, 0, "00042");
`endif
        repeat (18) @(negedge clk);
        prev = exp_chars;
        exp_chars = exp_shadow;
        evt_q.push_back({1'b1, exp_shadow});
        in_vblank = 1'b1;
        wait_idle(n, 100);
        chk("vblank_busy_no_commit", commit, 0);
        chk_grid("vblank_busy_chars_held", chars, prev);
        repeat (3) @(negedge clk);
        in_vblank = 1'b0;

        // Vblank that ends while busy: commit deferred to the next vblank
        send(0, 0, 2, 6, 3, 1'b0);
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        put_str(2, 6, "  0");
`else
        put_str(2, 6, "000");
`endif
        repeat (5) @(negedge clk);
        in_vblank = 1'b1;
        repeat (5) @(negedge clk);
        in_vblank = 1'b0;
        wait_idle(n, 100);
        repeat (6) @(negedge clk);
        chk_grid("missed_vblank_chars_held", chars, exp_chars);
        do_commit();

        // Reset mid-CONVERT discards the transfer and restores reset values
        send(0, 12345, 3, 0, 5, 1'b0);
        repeat (5) @(negedge clk);
        chk("midconvert_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_grid("midreset_chars", chars, spaces);
        chk("midreset_ready", req_ready, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_commit", commit, 0);
        chk("midreset_field_err", field_err, 0);
        reset = 1'b0;
        exp_shadow = spaces;
        exp_chars  = spaces;
        @(negedge clk);
        in_vblank = 1'b1;
        repeat (4) @(negedge clk);
        in_vblank = 1'b0;
        send(0, 7, 0, 0, 3, 1'b0);
`ifdef TELEM_LEADING_ZERO_BLANK_EN
        put_str(0, 0, "  7");
`else
        put_str(0, 0, "007");
`endif
        wait_idle(n, 100);
        do_commit();

        repeat (5) @(negedge clk);
        chk("event_queue_drained", evt_q.size(), 0);
        chk("grant_queue_drained", exp_grant.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
